bit_serial_adder: RTL

BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

---
 rtl/bit_serial_adder.sv | 94 +++++++++
 1 files changed

// File: rtl/bit_serial_adder.sv
// Bit-serial add/subtract: one full-adder cell processes WIDTH operand bits
// LSB-first, one bit per clock, and publishes sum/carry/overflow on completion.
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  // Counter is wide enough to hold WIDTH itself, so WIDTH=64 never wraps.
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic             carry_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic             bit_s;
  logic             bit_c;
  logic [WIDTH-1:0] res_next;

  assign bit_s = a_reg[0] ^ b_reg[0] ^ carry_reg;
  assign bit_c = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry_reg) | (b_reg[0] & carry_reg);

  // New sum bit enters at the MSB; written as a shift/or so WIDTH=1 needs no special case.
  assign res_next = (res_reg >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
            a_reg     <= a;
            b_reg     <= sub ? ~b : b;
            carry_reg <= sub;
            cnt_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          a_reg     <= a_reg >> 1;
          b_reg     <= b_reg >> 1;
          res_reg   <= res_next;
          carry_reg <= bit_c;
          cnt_reg   <= cnt_reg + 1'b1;
          if (cnt_reg == LAST) begin
            // carry_reg is the carry into the MSB, bit_c the carry out of it.
            sum       <= res_next;
            carry_out <= bit_c;
            overflow  <= carry_reg ^ bit_c;
            done      <= 1'b1;
            busy      <= 1'b0;
            state_reg <= DONE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
